// File: rtl/core_if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by core_if_fetch and core_if_skid.
package core_if_fetch_pkg;

   localparam logic [31:0] INST_NOP        = 32'h0000_0013;
   localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
   localparam logic [31:0] CPU_RST_ADDRESS = 32'h0000_0000;
   localparam int unsigned INST_BYTE_WIDTH = 32;

   typedef enum logic [1:0] {
      IF_S_IDLE    = 2'd0,
      IF_S_FETCH   = 2'd1,
      IF_S_DISCARD = 2'd2
   } if_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
   } if_id_t;

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/core_if_skid.sv
// One-entry {inst, addr} skid buffer for the fetch output stage.
// Clear wins over load, load wins over unload.
module core_if_skid
   import core_if_fetch_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   unload,
   input  logic   clear,
   input  if_id_t din,
   output if_id_t dout,
   output logic   valid
);

   // Capture a bypassed fetch while decode is stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         dout  <= '{inst: INST_NOP, addr: ZERO_WORD};
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/core_if_fetch.sv
// Instruction fetch: owns the PC, drives the req/ack bus,
// and feeds decode through a registered stage plus skid.
module core_if_fetch
   import core_if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = CPU_RST_ADDRESS,
   parameter int unsigned INST_BYTES = INST_BYTE_WIDTH / 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_in,
   input  logic [31:0] jump_addr_in,
   input  logic        hold_in,
   output logic        ibus_req_out,
   output logic [31:0] ibus_addr_out,
   input  logic        ibus_ack_in,
   input  logic [31:0] ibus_data_in,
   output logic [31:0] inst_out,
   output logic [31:0] inst_addr_out,
   output logic        inst_valid_out
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   if_id_t      out_q, out_d;
   logic        out_vld_q, out_vld_d;

   logic        buf_valid;
   if_id_t      buf_data;
   logic        buf_load;
   logic        buf_unload;

   logic        accept;
   logic [31:0] jump_tgt;
   if_id_t      ack_word;

   assign jump_tgt       = align_word(jump_addr_in);
   assign ack_word       = '{inst: ibus_data_in, addr: pc_q};
   assign ibus_addr_out  = pc_q;
   assign accept         = (state_q == IF_S_FETCH) && ibus_req_out
                        && ibus_ack_in && !jump_en_in;
   assign inst_out       = out_q.inst;
   assign inst_addr_out  = out_q.addr;
   assign inst_valid_out = out_vld_q;

   // State, PC and pending redirect registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IF_S_IDLE;
         pc_q    <= RESET_ADDR;
         pend_q  <= RESET_ADDR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
      end
   end

   // Next state, bus request and PC selection
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_d       = pend_q;
      ibus_req_out = 1'b0;
      unique case (state_q)
         IF_S_IDLE: begin
            state_d = IF_S_FETCH;
            if (jump_en_in) pc_d = jump_tgt;
         end
         IF_S_FETCH: begin
            ibus_req_out = ~buf_valid;
            if (jump_en_in) begin
               if (ibus_req_out && !ibus_ack_in) begin
                  pend_d  = jump_tgt;
                  state_d = IF_S_DISCARD;
               end else begin
                  pc_d = jump_tgt;
               end
            end else if (ibus_req_out && ibus_ack_in) begin
               pc_d = pc_q + 32'(INST_BYTES);
            end
         end
         IF_S_DISCARD: begin
            ibus_req_out = 1'b1;
            if (ibus_ack_in) begin
               state_d = IF_S_FETCH;
               pc_d    = jump_en_in ? jump_tgt : pend_q;
            end else if (jump_en_in) begin
               pend_d = jump_tgt;
            end
         end
         default: state_d = IF_S_IDLE;
      endcase
   end

   // Route accepted data between output stage and skid
   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      buf_load   = 1'b0;
      buf_unload = 1'b0;
      if (jump_en_in) begin
         out_d     = '{inst: INST_NOP, addr: ZERO_WORD};
         out_vld_d = 1'b0;
      end else if (!hold_in) begin
         if (buf_valid) begin
            out_d      = buf_data;
            out_vld_d  = 1'b1;
            buf_unload = 1'b1;
            buf_load   = accept;
         end else if (accept) begin
            out_d     = ack_word;
            out_vld_d = 1'b1;
         end else begin
            out_d     = '{inst: INST_NOP, addr: ZERO_WORD};
            out_vld_d = 1'b0;
         end
      end else if (accept) begin
         if (!out_vld_q) begin
            out_d     = ack_word;
            out_vld_d = 1'b1;
         end else begin
            buf_load = 1'b1;
         end
      end
   end

   // Registered output stage towards decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q     <= '{inst: INST_NOP, addr: ZERO_WORD};
         out_vld_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
      end
   end

   core_if_skid u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (buf_load),
      .unload (buf_unload),
      .clear  (jump_en_in),
      .din    (ack_word),
      .dout   (buf_data),
      .valid  (buf_valid)
   );

   // A full skid must never be offered more data while stalled
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(accept && buf_valid && hold_in));
      end
   end

endmodule
